delay_line_reader: RTL and testbench



---
 rtl/delay_line_reader_pkg.sv | 19 +
 rtl/delay_line_reader_shift_add_gain.sv | 57 +++++
 rtl/delay_line_reader.sv | 147 ++++++++++++++
 tb/tb_delay_line_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_line_reader_pkg.sv
// Shared types and fixed-point constants for the delay-line read path.
package delay_line_reader_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 16;
  localparam int GAIN_FRAC  = 8;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_MULT,
    ST_OUT
  } state_t;

endpackage

// File: rtl/delay_line_reader_shift_add_gain.sv
// Sequential signed x unsigned shift-add multiplier: one partial product per cycle,
// COEF_W cycles after start; done is asserted alongside the final product.
module shift_add_gain
  import delay_line_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic signed [DATA_W-1:0]        mcand,
  input  logic        [COEF_W-1:0]        mplier,
  output logic                            done,
  output logic signed [DATA_W+COEF_W-1:0] product
);
  localparam int PW = DATA_W + COEF_W;
  localparam int CW = $clog2(COEF_W);

  logic                 running;
  logic [CW-1:0]        cnt;
  logic signed [PW-1:0] acc_p0;
  logic signed [PW-1:0] addend_p0;
  logic [COEF_W-1:0]    bits_p0;
  logic signed [PW-1:0] sum;

  assign sum     = bits_p0[0] ? (acc_p0 + addend_p0) : acc_p0;
  assign done    = running && (cnt == CW'(COEF_W - 1));
  assign product = sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
    end else if (running) begin
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

  // Accumulate stage: addend walks left one bit while the multiplier walks right.
  always_ff @(posedge clk) begin
    if (start) begin
      acc_p0    <= '0;
      addend_p0 <= PW'(mcand);
      bits_p0   <= mplier;
    end else if (running) begin
      acc_p0    <= sum;
      addend_p0 <= addend_p0 <<< 1;
      bits_p0   <= bits_p0 >> 1;
    end
  end

endmodule

// File: rtl/delay_line_reader.sv
// Read side of the pedal sample memory: per ADC tick, pick a delay-tap or loop address,
// fetch one word (internal fixed latency or off-chip handshake), scale by Q8.8 gain, saturate.
module delay_line_reader
  import delay_line_reader_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adc_clock,
  input  logic                     loop,
  input  logic                     off_chip_mem,
  input  logic                     off_chip_mem_ready,
  input  logic [ADDR_W-1:0]        write_addr,
  input  logic [15:0]              delay_reverb,
  input  logic [ADDR_W-1:0]        loop_length,
  input  logic [15:0]              gain,
  input  logic signed [DATA_W-1:0] mem_data_in,
  output logic                     mem_re,
  output logic [ADDR_W-1:0]        address_out,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     data_valid,
  output logic                     busy,
  output logic                     underrun,
  output logic                     timeout
);
  localparam int COEF_W = 16;
  localparam int PW     = DATA_W + COEF_W;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  function automatic logic signed [DATA_W-1:0] sat_scale(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p >>> GAIN_FRAC;
    if (s > PW'(SAT_MAX)) return DATA_W'(SAT_MAX);
    if (s < PW'(SAT_MIN)) return DATA_W'(SAT_MIN);
    return s[DATA_W-1:0];
  endfunction

  state_t                  state_q, state_d;
  logic                    adc_s1, adc_s2, adc_s3;
  logic                    tick;
  logic                    oc_q;
  logic                    req_phase_q;
  logic [CNT_W-1:0]        wait_cnt_q;
  logic [ADDR_W-1:0]       loop_ptr_q;
  logic signed [DATA_W-1:0] sample_p0;
  logic signed [DATA_W-1:0] mcand;
  logic                    mult_start, mult_done;
  logic signed [PW-1:0]    product;
  logic                    req_ack, req_abort;

  assign tick     = adc_s2 & ~adc_s3;
  assign busy     = (state_q != ST_IDLE);
  assign underrun = tick && (state_q != ST_IDLE);
  assign mcand    = oc_q ? sample_p0 : mem_data_in;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // req_phase_q=1 means the word is in hand (or due on mem_data_in) and the multiply can start.
  always_comb begin
    state_d    = state_q;
    mult_start = 1'b0;
    req_ack    = 1'b0;
    req_abort  = 1'b0;
    case (state_q)
      ST_IDLE: if (tick) state_d = ST_REQ;
      ST_REQ: begin
        if (req_phase_q) begin
          mult_start = 1'b1;
          state_d    = ST_MULT;
        end else if (oc_q) begin
          if (off_chip_mem_ready)                      req_ack   = 1'b1;
          else if (wait_cnt_q == CNT_W'(TIMEOUT - 1))  req_abort = 1'b1;
        end
      end
      ST_MULT: if (mult_done) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adc_s1      <= 1'b0;
      adc_s2      <= 1'b0;
      adc_s3      <= 1'b0;
      mem_re      <= 1'b0;
      address_out <= '0;
      oc_q        <= 1'b0;
      req_phase_q <= 1'b0;
      wait_cnt_q  <= '0;
      timeout     <= 1'b0;
      data_valid  <= 1'b0;
      data_out    <= '0;
      loop_ptr_q  <= '0;
    end else begin
      {adc_s3, adc_s2, adc_s1} <= {adc_s2, adc_s1, adc_clock};
      timeout    <= req_abort;
      data_valid <= (state_q == ST_MULT) && mult_done;
      if ((state_q == ST_IDLE) && tick) begin
        address_out <= loop ? loop_ptr_q : (write_addr - ADDR_W'(delay_reverb));
        mem_re      <= 1'b1;
        oc_q        <= off_chip_mem;
        req_phase_q <= 1'b0;
        wait_cnt_q  <= '0;
      end else if ((state_q == ST_REQ) && !req_phase_q) begin
        if (!oc_q || req_ack || req_abort) begin
          mem_re      <= 1'b0;
          req_phase_q <= 1'b1;
        end else begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
      end
      if ((state_q == ST_MULT) && mult_done) data_out <= sat_scale(product);
      // loop_length of 0 wraps at 2^ADDR_W because loop_length-1 underflows to all ones.
      if (!loop)
        loop_ptr_q <= '0;
      else if ((state_q == ST_IDLE) && tick)
        loop_ptr_q <= (loop_ptr_q == loop_length - 1'b1) ? '0 : loop_ptr_q + 1'b1;
    end
  end

  // Capture stage: off-chip word (or zero on abort) held for the multiplier.
  always_ff @(posedge clk) begin
    if (req_ack)        sample_p0 <= mem_data_in;
    else if (req_abort) sample_p0 <= '0;
  end

  shift_add_gain #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W)
  ) u_mult (
    .clk    (clk),
    .rst    (rst),
    .start  (mult_start),
    .mcand  (mcand),
    .mplier (gain),
    .done   (mult_done),
    .product(product)
  );

endmodule

// File: tb/tb_delay_line_reader.sv
// Scoreboard bench for delay_line_reader with a memory responder and a behavioural model.
module tb_delay_line_reader;
  localparam int TMO = 255;

  logic clk = 1'b0;
  logic rst, adc_clock, loop, off_chip_mem, off_chip_mem_ready;
  logic [15:0] write_addr, delay_reverb, loop_length, gain;
  logic signed [15:0] mem_data_in;
  logic mem_re, data_valid, busy, underrun, timeout;
  logic [15:0] address_out;
  logic signed [15:0] data_out;

  delay_line_reader #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .adc_clock(adc_clock), .loop(loop), .off_chip_mem(off_chip_mem),
    .off_chip_mem_ready(off_chip_mem_ready), .write_addr(write_addr), .delay_reverb(delay_reverb),
    .loop_length(loop_length), .gain(gain), .mem_data_in(mem_data_in), .mem_re(mem_re),
    .address_out(address_out), .data_out(data_out), .data_valid(data_valid), .busy(busy),
    .underrun(underrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] addr; int t_re; int re_len; } req_exp_t;
  typedef struct { logic [15:0] data; int t_valid; } out_exp_t;
  req_exp_t req_q[$];
  out_exp_t out_q[$];

  logic [15:0] mem [0:65535];
  int  n_checks = 0, n_fail = 0;
  int  m_ptr = 0;
  int  ready_at = 0;
  logic oc_mode = 1'b0;
  int  n_underrun = 0, last_underrun = -1, n_timeout = 0, last_timeout = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Q8.8 scaling by plain arithmetic: floor(sample*gain/256), clamped to 16-bit signed.
  function automatic logic [15:0] model_gain(input logic signed [15:0] s, input logic [15:0] g);
    longint p, q;
    p = longint'(s) * longint'(g);
    q = p / 256;
    if ((p < 0) && (p % 256 != 0)) q = q - 1;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  task automatic issue(input logic lp, input logic oc, input logic [15:0] wa, input logic [15:0] dly,
                       input logic signed [15:0] smp, input logic [15:0] g, input int rdy,
                       input bit live, output int t_tick);
    logic [15:0] a;
    int len, wlen;
    req_exp_t r;
    out_exp_t o;
    @(negedge clk);
    loop = lp; off_chip_mem = oc; write_addr = wa; delay_reverb = dly; gain = g;
    ready_at = rdy; oc_mode = oc;
    if (!lp) m_ptr = 0;
    len = (loop_length == 16'h0) ? 65536 : int'(loop_length);
    a   = lp ? 16'(m_ptr) : 16'((int'(wa) - int'(dly) + 65536) % 65536);
    if (lp) m_ptr = (m_ptr + 1) % len;
    mem[a] = smp;
    t_tick = cyc + 2;
    adc_clock = 1'b1;
    wlen = oc ? ((rdy == 0) ? TMO : rdy) : 1;
    r.addr = a; r.t_re = t_tick + 1; r.re_len = live ? wlen : -1;
    req_q.push_back(r);
    if (live) begin
      o.data    = model_gain((oc && rdy == 0) ? 16'sh0 : smp, g);
      o.t_valid = t_tick + 19 + (wlen - 1);
      out_q.push_back(o);
    end
    @(negedge clk);
    adc_clock = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (((out_q.size() != 0) || busy) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check("drain_within_budget", 32'(n < budget), 32'd1);
  endtask

  // Memory responder: internal returns the word one cycle after mem_re; off-chip raises ready
  // on the ready_at-th request cycle. Other cycles carry junk so wrong capture timing shows up.
  initial begin
    int n = 0;
    bit pend = 1'b0;
    logic [15:0] pa = '0;
    off_chip_mem_ready = 1'b0;
    mem_data_in = '0;
    forever begin
      @(negedge clk);
      off_chip_mem_ready = 1'b0;
      mem_data_in = 16'($urandom);
      if (pend) mem_data_in = mem[pa];
      pend = 1'b0;
      if (mem_re) begin
        n++;
        if (!oc_mode) begin
          pend = 1'b1;
          pa = address_out;
        end else if (n == ready_at) begin
          off_chip_mem_ready = 1'b1;
          mem_data_in = mem[address_out];
        end
      end else begin
        n = 0;
      end
    end
  end

  // Monitor: pops expectations when the DUT raises mem_re or data_valid.
  initial begin
    logic prev_re, prev_dv, stable_ok;
    logic [15:0] addr_lat;
    int re_cnt, re_len_exp;
    req_exp_t r;
    out_exp_t o;
    prev_re = 1'b0; prev_dv = 1'b0; stable_ok = 1'b1; addr_lat = '0; re_cnt = 0; re_len_exp = -1;
    forever begin
      @(negedge clk);
      if (mem_re && !prev_re) begin
        if (req_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_mem_re: address %0h with no pending request", address_out);
          re_len_exp = -1;
        end else begin
          r = req_q.pop_front();
          check("read_address", 32'(address_out), 32'(r.addr));
          check("mem_re_cycle", cyc, r.t_re);
          re_len_exp = r.re_len;
        end
        addr_lat = address_out; re_cnt = 0; stable_ok = 1'b1;
      end
      if (mem_re) begin
        re_cnt++;
        if (address_out !== addr_lat) stable_ok = 1'b0;
      end
      if (!mem_re && prev_re && (re_len_exp >= 0)) begin
        check("mem_re_length", re_cnt, re_len_exp);
        check("address_stable", 32'(stable_ok), 32'd1);
      end
      prev_re = mem_re;
      if (data_valid) begin
        if (out_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_data_valid: data_out %0h with no pending sample", data_out);
        end else begin
          o = out_q.pop_front();
          check("data_out", 32'($unsigned(data_out)), 32'(o.data));
          check("data_valid_cycle", cyc, o.t_valid);
          check("data_valid_pulse", 32'(prev_dv), 32'd0);
        end
      end
      prev_dv = data_valid;
      if (underrun) begin n_underrun++; last_underrun = cyc; end
      if (timeout)  begin n_timeout++;  last_timeout  = cyc; end
    end
  end

  initial begin
    int t, u0;
    rst = 1'b1; adc_clock = 1'b0; loop = 1'b0; off_chip_mem = 1'b0; write_addr = '0;
    delay_reverb = '0; loop_length = 16'd3; gain = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_re", 32'(mem_re), 0);
    check("rst_address_out", 32'(address_out), 0);
    check("rst_data_out", 32'($unsigned(data_out)), 0);
    check("rst_data_valid", 32'(data_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_timeout", 32'(timeout), 0);
    rst = 1'b0;

    issue(1'b0, 1'b0, 16'h0010, 16'h0004, 16'sh1234, 16'h0100, 0, 1'b1, t); wait_done(400);
    issue(1'b0, 1'b0, 16'h0002, 16'h0005, 16'sh8000, 16'h0080, 0, 1'b1, t); wait_done(400);
    issue(1'b0, 1'b0, 16'h0100, 16'h0000, 16'sh5000, 16'h0200, 0, 1'b1, t); wait_done(400);
    issue(1'b0, 1'b0, 16'h0200, 16'h0001, 16'shB000, 16'h0200, 0, 1'b1, t); wait_done(400);

    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'h0100, 0, 1'b1, t);
      wait_done(400);
    end
    issue(1'b0, 1'b0, 16'h0050, 16'h0010, 16'sh0321, 16'h0100, 0, 1'b1, t); wait_done(400);
    issue(1'b1, 1'b0, 16'h0050, 16'h0010, 16'sh0654, 16'h0180, 0, 1'b1, t); wait_done(400);

    issue(1'b0, 1'b1, 16'h1000, 16'h0010, 16'sh0ABC, 16'h0100, 7, 1'b1, t); wait_done(400);
    issue(1'b0, 1'b1, 16'h2000, 16'h0020, -16'sd300, 16'h0333, 1, 1'b1, t); wait_done(400);

    u0 = n_timeout;
    issue(1'b0, 1'b1, 16'h3000, 16'h0001, 16'sh7777, 16'h0100, 0, 1'b1, t); wait_done(400);
    check("timeout_count", n_timeout, u0 + 1);
    check("timeout_cycle", last_timeout, t + 256);

    u0 = n_underrun;
    issue(1'b0, 1'b0, 16'h4000, 16'h0003, 16'sh1111, 16'h0100, 0, 1'b1, t);
    repeat (9) @(negedge clk);
    adc_clock = 1'b1;
    @(negedge clk);
    adc_clock = 1'b0;
    wait_done(400);
    check("underrun_count", n_underrun, u0 + 1);
    check("underrun_cycle", last_underrun, t + 10);

    issue(1'b0, 1'b1, 16'h2222, 16'h0002, 16'sh0777, 16'h0100, 100, 1'b0, t);
    repeat (5) @(negedge clk);
    check("re_before_reset", 32'(mem_re), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("reset_drops_mem_re", 32'(mem_re), 32'd0);
    check("reset_clears_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    m_ptr = 0;
    repeat (30) @(negedge clk);
    issue(1'b0, 1'b0, 16'h0777, 16'h0007, 16'sh2468, 16'h0100, 0, 1'b1, t); wait_done(400);

    loop_length = 16'd5;
    for (int i = 0; i < 20; i++) begin
      logic lp, oc;
      lp = 1'($urandom_range(0, 1));
      oc = 1'($urandom_range(0, 1));
      issue(lp, oc, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            oc ? int'($urandom_range(1, 12)) : 0, 1'b1, t);
      wait_done(400);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", req_q.size() + out_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
